crc_frame_engine: RTL and testbench

- Parametrised successor to the team's fixed 8-bit serial CRC block.
- Accepts a frame of one or more DATA_W-bit words through a valid/ready handshake and runs them LSB-first through a CRC_W-bit Galois LFSR, one bit per clock.
- After the last word it shifts the CRC out serially on crc_out with valid high, and also holds it in parallel on crc_value.
- Sits between the byte-stream source and the serial link framer.

---
 rtl/crc_frame_engine.sv | 164 ++++++++++++++++
 tb/tb_crc_frame_engine.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_engine.sv
// Framed serial CRC engine: DATA_W-bit words in through valid/ready, CRC_W-bit Galois LFSR, CRC out serially and in parallel.
// Optional macro CRC_FINAL_XOR_EN inverts the final CRC on entry to OUT.
module crc_frame_engine #(
   parameter int unsigned      DATA_W = 8,
   parameter int unsigned      CRC_W  = 8,
   parameter logic [CRC_W-1:0] POLY   = 8'h44,
   parameter logic [CRC_W-1:0] SEED   = 8'hD8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              busy,
   output logic              crc_out,
   output logic              valid,
   output logic [CRC_W-1:0]  crc_value
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] OUT   = 2'd3;

   localparam int BCNT_W = $clog2(DATA_W + 1);
   localparam int OCNT_W = $clog2(CRC_W + 1);
   localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_W - 1);
   localparam logic [OCNT_W-1:0] OCNT_LAST = OCNT_W'(CRC_W - 1);

   logic [1:0]        state_q, state_d;
   logic [CRC_W-1:0]  lfsr_q, lfsr_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              last_q, last_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   logic [OCNT_W-1:0] ocnt_q, ocnt_d;
   logic [CRC_W-1:0]  crc_value_q, crc_value_d;
   logic              crc_out_q, crc_out_d;
   logic              valid_q, valid_d;
   logic [CRC_W-1:0]  lfsr_nx;
   logic [CRC_W-1:0]  fin_crc;

   function automatic logic [CRC_W-1:0] lfsr_step(input logic [CRC_W-1:0] l, input logic d);
      logic [CRC_W-1:0] n;
      logic             fb;
      fb = d ^ l[0];
      for (int i = 0; i < int'(CRC_W) - 1; i++) begin
         n[i] = l[i+1] ^ (POLY[i] & fb);
      end
      n[CRC_W-1] = fb;
      return n;
   endfunction

   function automatic logic [CRC_W-1:0] crc_final(input logic [CRC_W-1:0] c);
`ifdef CRC_FINAL_XOR_EN
      return ~c;
`else
      return c;
`endif
   endfunction

   assign lfsr_nx = lfsr_step(lfsr_q, sh_q[0]);
   assign fin_crc = crc_final(lfsr_nx);

   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      sh_d        = sh_q;
      last_d      = last_q;
      bcnt_d      = bcnt_q;
      ocnt_d      = ocnt_q;
      crc_value_d = crc_value_q;
      crc_out_d   = crc_out_q;
      valid_d     = valid_q;
      // clr outranks every transition, including an accept in the same cycle
      if (clr) begin
         state_d   = IDLE;
         lfsr_d    = SEED;
         valid_d   = 1'b0;
         crc_out_d = 1'b0;
         bcnt_d    = '0;
         ocnt_d    = '0;
      end else begin
         case (state_q)
            IDLE, WAIT: begin
               if (in_valid) begin
                  sh_d    = in_data;
                  last_d  = in_last;
                  bcnt_d  = '0;
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               lfsr_d = lfsr_nx;
               sh_d   = sh_q >> 1;
               bcnt_d = bcnt_q + 1'b1;
               if (bcnt_q == BCNT_LAST) begin
                  bcnt_d = '0;
                  if (last_q) begin
                     lfsr_d      = fin_crc;
                     crc_value_d = fin_crc;
                     crc_out_d   = fin_crc[0];
                     valid_d     = 1'b1;
                     ocnt_d      = '0;
                     state_d     = OUT;
                  end else begin
                     state_d = WAIT;
                  end
               end
            end
            OUT: begin
               if (ocnt_q == OCNT_LAST) begin
                  state_d   = IDLE;
                  lfsr_d    = SEED;
                  valid_d   = 1'b0;
                  crc_out_d = 1'b0;
                  ocnt_d    = '0;
               end else begin
                  // plain shift: bit 1 becomes the next serial bit
                  lfsr_d    = lfsr_q >> 1;
                  crc_out_d = lfsr_q[1];
                  ocnt_d    = ocnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         lfsr_q      <= SEED;
         last_q      <= 1'b0;
         bcnt_q      <= '0;
         ocnt_q      <= '0;
         crc_value_q <= '0;
         crc_out_q   <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         last_q      <= last_d;
         bcnt_q      <= bcnt_d;
         ocnt_q      <= ocnt_d;
         crc_value_q <= crc_value_d;
         crc_out_q   <= crc_out_d;
         valid_q     <= valid_d;
      end
   end

   // data shift register carries no reset; it is loaded on every accept
   always_ff @(posedge clk) begin
      sh_q <= sh_d;
   end

   assign in_ready  = (state_q == IDLE) || (state_q == WAIT);
   assign busy      = (state_q != IDLE);
   assign crc_out   = crc_out_q;
   assign valid     = valid_q;
   assign crc_value = crc_value_q;

endmodule

// File: tb/tb_crc_frame_engine.sv
// Directed bench for crc_frame_engine: default 8-bit instance plus a 16-bit CRC-16/X.25 style instance.
module tb_crc_frame_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, clr;
   logic        v8, l8, r8, b8, o8, vo8;
   logic [7:0]  d8, cv8;
   logic        v16, l16, r16, b16, o16, vo16;
   logic [15:0] d16, cv16;

   int checks = 0;
   int errors = 0;

`ifdef CRC_FINAL_XOR_EN
   localparam logic XOR_EN = 1'b1;
`else
   localparam logic XOR_EN = 1'b0;
`endif
   // hand-derived: one zero byte from D8 gives 14, two zero bytes give EB
   localparam logic [7:0] EXP_ONE = XOR_EN ? 8'hEB : 8'h14;
   localparam logic [7:0] EXP_TWO = XOR_EN ? 8'h14 : 8'hEB;

   crc_frame_engine dut8 (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(v8), .in_data(d8), .in_last(l8),
      .in_ready(r8), .busy(b8), .crc_out(o8), .valid(vo8), .crc_value(cv8)
   );

   crc_frame_engine #(.DATA_W(16), .CRC_W(16), .POLY(16'h8408), .SEED(16'hFFFF)) dut16 (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(v16), .in_data(d16), .in_last(l16),
      .in_ready(r16), .busy(b16), .crc_out(o16), .valid(vo16), .crc_value(cv16)
   );

   // byte-at-a-time reflected CRC reference
   function automatic logic [31:0] ref_byte(input logic [31:0] crc, input logic [7:0] b, input logic [31:0] mask);
      logic [31:0] c;
      c = crc ^ {24'd0, b};
      for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ mask) : (c >> 1);
      return c;
   endfunction

   function automatic logic [7:0] fin8(input logic [31:0] c);
      return XOR_EN ? ~c[7:0] : c[7:0];
   endfunction

   function automatic logic [15:0] fin16(input logic [31:0] c);
      return XOR_EN ? ~c[15:0] : c[15:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit wide, input logic [15:0] data, input logic last);
      int n;
      n = 0;
      while (((wide ? r16 : r8) !== 1'b1) && n < 200) begin tick(); n++; end
      if (n == 200) begin
         checks++; errors++;
         $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", wide ? r16 : r8, n);
      end
      if (wide) begin v16 = 1'b1; d16 = data; l16 = last; end
      else begin v8 = 1'b1; d8 = data[7:0]; l8 = last; end
      tick();
      v8 = 1'b0; v16 = 1'b0;
   endtask

   task automatic collect(input bit wide, input int n, output logic [15:0] bits, output int lat, output bit stayed);
      lat = 0; bits = '0; stayed = 1'b1;
      while (((wide ? vo16 : vo8) !== 1'b1) && lat < 100) begin tick(); lat++; end
      for (int i = 0; i < n; i++) begin
         if (i > 0) tick();
         if ((wide ? vo16 : vo8) !== 1'b1) stayed = 1'b0;
         bits[i] = wide ? o16 : o8;
      end
   endtask

   task automatic test_reset();
      #12;
      checks += 7;
      if (r8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", r8); end
      if (b8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", b8); end
      if (vo8 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", vo8); end
      if (o8 !== 1'b0) begin errors++; $display("FAIL reset_crc_out: got %b want 0", o8); end
      if (cv8 !== 8'h00) begin errors++; $display("FAIL reset_crc_value: got %h want 00", cv8); end
      if (r16 !== 1'b1) begin errors++; $display("FAIL reset_in_ready16: got %b want 1", r16); end
      if (cv16 !== 16'h0000) begin errors++; $display("FAIL reset_crc_value16: got %h want 0000", cv16); end
      @(posedge clk); #1; rst = 1'b1;
      tick();
      checks++;
      if (b8 !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", b8); end
   endtask

   task automatic test_single_word();
      logic [15:0] bits; int lat; bit stayed;
      send(1'b0, 16'h0000, 1'b1);
      checks += 2;
      if (r8 !== 1'b0) begin errors++; $display("FAIL single_ready_in_shift: got %b want 0", r8); end
      if (b8 !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", b8); end
      collect(1'b0, 8, bits, lat, stayed);
      checks += 4;
      if (lat !== 8) begin errors++; $display("FAIL single_latency: got %0d want 8", lat); end
      if (stayed !== 1'b1) begin errors++; $display("FAIL single_valid_width: got %b want 1", stayed); end
      if (bits[7:0] !== EXP_ONE) begin errors++; $display("FAIL single_serial: got %h want %h", bits[7:0], EXP_ONE); end
      if (cv8 !== EXP_ONE) begin errors++; $display("FAIL single_crc_value: got %h want %h", cv8, EXP_ONE); end
      tick();
      checks += 3;
      if (vo8 !== 1'b0) begin errors++; $display("FAIL single_valid_fall: got %b want 0", vo8); end
      if (r8 !== 1'b1) begin errors++; $display("FAIL single_ready_back: got %b want 1", r8); end
      if (b8 !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b want 0", b8); end
   endtask

   task automatic test_two_word_gap();
      logic [15:0] bits; int lat; bit stayed; int n;
      send(1'b0, 16'h0000, 1'b0);
      send(1'b0, 16'h0000, 1'b1);
      collect(1'b0, 8, bits, lat, stayed);
      checks += 2;
      if (bits[7:0] !== EXP_TWO) begin errors++; $display("FAIL gap0_serial: got %h want %h", bits[7:0], EXP_TWO); end
      if (cv8 !== EXP_TWO) begin errors++; $display("FAIL gap0_crc_value: got %h want %h", cv8, EXP_TWO); end
      tick();
      send(1'b0, 16'h0000, 1'b0);
      n = 0;
      while (r8 !== 1'b1 && n < 50) begin tick(); n++; end
      repeat (5) tick();
      checks += 4;
      if (r8 !== 1'b1) begin errors++; $display("FAIL gap5_wait_ready: got %b want 1", r8); end
      if (b8 !== 1'b1) begin errors++; $display("FAIL gap5_wait_busy: got %b want 1", b8); end
      if (vo8 !== 1'b0) begin errors++; $display("FAIL gap5_wait_valid: got %b want 0", vo8); end
      if (cv8 !== EXP_TWO) begin errors++; $display("FAIL gap5_held_value: got %h want %h", cv8, EXP_TWO); end
      send(1'b0, 16'h0000, 1'b1);
      collect(1'b0, 8, bits, lat, stayed);
      checks += 2;
      if (bits[7:0] !== EXP_TWO) begin errors++; $display("FAIL gap5_serial: got %h want %h", bits[7:0], EXP_TWO); end
      if (cv8 !== EXP_TWO) begin errors++; $display("FAIL gap5_crc_value: got %h want %h", cv8, EXP_TWO); end
      tick();
   endtask

   task automatic test_ignore_busy();
      logic [7:0] f1, f2, e1, e2, dat0, dat17;
      int vcnt;
      f1 = '0; f2 = '0; vcnt = 0;
      dat0 = 8'(5); dat17 = 8'(17 * 37 + 5);
      e1 = fin8(ref_byte(32'hD8, dat0, 32'hC4));
      e2 = fin8(ref_byte(32'hD8, dat17, 32'hC4));
      for (int c = 0; c < 34; c++) begin
         v8 = 1'b1; l8 = 1'b1; d8 = 8'(c * 37 + 5);
         tick();
         if (vo8 === 1'b1) vcnt++;
         if (c >= 8 && c <= 15) f1[c-8] = o8;
         if (c >= 25 && c <= 32) f2[c-25] = o8;
      end
      v8 = 1'b0;
      checks += 5;
      if (vcnt !== 16) begin errors++; $display("FAIL busy_valid_cycles: got %0d want 16", vcnt); end
      if (f1 !== e1) begin errors++; $display("FAIL busy_frame1: got %h want %h", f1, e1); end
      if (f2 !== e2) begin errors++; $display("FAIL busy_frame2: got %h want %h", f2, e2); end
      if (cv8 !== e2) begin errors++; $display("FAIL busy_crc_value: got %h want %h", cv8, e2); end
      if (b8 !== 1'b0) begin errors++; $display("FAIL busy_idle_after: got %b want 0", b8); end
      tick();
   endtask

   task automatic test_clr();
      logic [15:0] bits; int lat; bit stayed; int vcnt;
      logic [7:0] prev;
      prev = fin8(ref_byte(32'hD8, 8'h5A, 32'hC4));
      send(1'b0, 16'h005A, 1'b1);
      collect(1'b0, 8, bits, lat, stayed);
      tick();
      checks++;
      if (cv8 !== prev) begin errors++; $display("FAIL clr_prev_value: got %h want %h", cv8, prev); end
      send(1'b0, 16'h00A5, 1'b1);
      repeat (3) tick();
      clr = 1'b1; v8 = 1'b1; d8 = 8'hFF;
      tick();
      clr = 1'b0; v8 = 1'b0;
      checks += 4;
      if (b8 !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b want 0", b8); end
      if (r8 !== 1'b1) begin errors++; $display("FAIL clr_ready: got %b want 1", r8); end
      if (vo8 !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b want 0", vo8); end
      if (cv8 !== prev) begin errors++; $display("FAIL clr_keeps_value: got %h want %h", cv8, prev); end
      clr = 1'b1; v8 = 1'b1; l8 = 1'b1; d8 = 8'h00;
      tick();
      clr = 1'b0; v8 = 1'b0;
      vcnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (vo8 === 1'b1) vcnt++;
         tick();
      end
      checks += 2;
      if (b8 !== 1'b0) begin errors++; $display("FAIL clr_drop_accept: got busy=%b want 0", b8); end
      if (vcnt !== 0) begin errors++; $display("FAIL clr_no_output: got %0d valid cycles want 0", vcnt); end
      send(1'b0, 16'h0000, 1'b1);
      checks++;
      if (cv8 !== prev) begin errors++; $display("FAIL clr_value_midframe: got %h want %h", cv8, prev); end
      collect(1'b0, 8, bits, lat, stayed);
      checks += 2;
      if (bits[7:0] !== EXP_ONE) begin errors++; $display("FAIL clr_next_serial: got %h want %h", bits[7:0], EXP_ONE); end
      if (cv8 !== EXP_ONE) begin errors++; $display("FAIL clr_next_value: got %h want %h", cv8, EXP_ONE); end
      tick();
   endtask

   task automatic test_reset_mid_out();
      logic [15:0] bits; int lat; bit stayed; int n;
      send(1'b0, 16'h003C, 1'b1);
      n = 0;
      while (vo8 !== 1'b1 && n < 50) begin tick(); n++; end
      repeat (3) tick();
      checks++;
      if (vo8 !== 1'b1) begin errors++; $display("FAIL rstout_in_out: got valid=%b want 1", vo8); end
      rst = 1'b0;
      #1;
      checks += 5;
      if (vo8 !== 1'b0) begin errors++; $display("FAIL rstout_valid: got %b want 0", vo8); end
      if (o8 !== 1'b0) begin errors++; $display("FAIL rstout_crc_out: got %b want 0", o8); end
      if (cv8 !== 8'h00) begin errors++; $display("FAIL rstout_crc_value: got %h want 00", cv8); end
      if (r8 !== 1'b1) begin errors++; $display("FAIL rstout_ready: got %b want 1", r8); end
      if (b8 !== 1'b0) begin errors++; $display("FAIL rstout_busy: got %b want 0", b8); end
      @(posedge clk); #1; rst = 1'b1;
      send(1'b0, 16'h0000, 1'b1);
      collect(1'b0, 8, bits, lat, stayed);
      checks += 2;
      if (bits[7:0] !== EXP_ONE) begin errors++; $display("FAIL rstout_next_serial: got %h want %h", bits[7:0], EXP_ONE); end
      if (cv8 !== EXP_ONE) begin errors++; $display("FAIL rstout_next_value: got %h want %h", cv8, EXP_ONE); end
      tick();
   endtask

   task automatic test_x25();
      logic [15:0] bits, exp, word; int lat; bit stayed; int nw;
      logic [31:0] c;
      c = 32'hFFFF;
      c = ref_byte(c, 8'h31, 32'h8408); c = ref_byte(c, 8'h32, 32'h8408);
      c = ref_byte(c, 8'h33, 32'h8408); c = ref_byte(c, 8'h34, 32'h8408);
      exp = fin16(c);
      send(1'b1, 16'h3231, 1'b0);
      send(1'b1, 16'h3433, 1'b1);
      collect(1'b1, 16, bits, lat, stayed);
      checks += 4;
      if (lat !== 16) begin errors++; $display("FAIL x25_latency: got %0d want 16", lat); end
      if (stayed !== 1'b1) begin errors++; $display("FAIL x25_valid_width: got %b want 1", stayed); end
      if (bits !== exp) begin errors++; $display("FAIL x25_serial: got %h want %h", bits, exp); end
      if (cv16 !== exp) begin errors++; $display("FAIL x25_crc_value: got %h want %h", cv16, exp); end
      tick();
      for (int f = 0; f < 100; f++) begin
         nw = int'($urandom_range(1, 3));
         c = 32'hFFFF;
         for (int w = 0; w < nw; w++) begin
            word = 16'($urandom);
            c = ref_byte(c, word[7:0], 32'h8408);
            c = ref_byte(c, word[15:8], 32'h8408);
            repeat ($urandom_range(0, 2)) tick();
            send(1'b1, word, (w == nw - 1));
         end
         exp = fin16(c);
         collect(1'b1, 16, bits, lat, stayed);
         checks += 2;
         if (bits !== exp) begin errors++; $display("FAIL rand_serial[%0d]: got %h want %h", f, bits, exp); end
         if (cv16 !== exp) begin errors++; $display("FAIL rand_crc_value[%0d]: got %h want %h", f, cv16, exp); end
         tick();
      end
   endtask

   initial begin
      rst = 1'b0; clr = 1'b0;
      v8 = 1'b0; l8 = 1'b0; d8 = 8'h00;
      v16 = 1'b0; l16 = 1'b0; d16 = 16'h0000;
      test_reset();
      test_single_word();
      test_two_word_gap();
      test_ignore_busy();
      test_clr();
      test_reset_mid_out();
      test_x25();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule
